// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Single outstanding request; responses return in order one or more cycles later.
`timescale 1ns/1ps
interface instr_fetch_unit_if #(
    parameter int PC_WIDTH = 32
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [31:0]         imem_rdata;
    logic                imem_rvalid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_rvalid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_rvalid
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// fills the IF/ID register, honouring stalls and discarding wrong-path words.
//
//   state | meaning
//   ISSUE | request at pc this cycle (suppressed by a redirect)
//   WAIT  | request outstanding, word is on the correct path
//   DROP  | request outstanding, word is wrong-path and will be discarded
//   HOLD  | word arrived during a stall and is parked in holdInstr
`timescale 1ns/1ps
module instr_fetch_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_unit_if.master   imem,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [PC_WIDTH-1:0]  branch_target,
    output logic                 if_id_valid,
    output logic [31:0]          if_id_instr,
    output logic [5:0]           if_id_opcode,
    output logic [PC_WIDTH-1:0]  if_id_pc_plus4
);

    typedef enum logic [1:0] {ISSUE, WAIT, DROP, HOLD} fetchState_t;

    fetchState_t         state;
    fetchState_t         stateNext;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pcNext;
    logic [PC_WIDTH-1:0] pcPlus4;
    logic [PC_WIDTH-1:0] targetAligned;
    logic [31:0]         holdInstr;
    logic [31:0]         holdNext;
    logic [31:0]         loadInstr;
    logic                loadEn;

    assign pcPlus4       = pc + PC_WIDTH'(4);
    assign targetAligned = {branch_target[PC_WIDTH-1:2], 2'b00};

    assign imem.imem_req  = !rst && (state == ISSUE) && !branch_taken;
    assign imem.imem_addr = pc;
    assign if_id_opcode   = if_id_instr[31:26];

    always_comb begin
        stateNext = state;
        pcNext    = pc;
        holdNext  = holdInstr;
        loadEn    = 1'b0;
        loadInstr = holdInstr;
        case (state)
            ISSUE: begin
                if (branch_taken) pcNext = targetAligned;
                else              stateNext = WAIT;
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    if (branch_taken) begin
                        pcNext    = targetAligned;
                        stateNext = ISSUE;
                    end else if (!stall) begin
                        loadEn    = 1'b1;
                        loadInstr = imem.imem_rdata;
                        pcNext    = pcPlus4;
                        stateNext = ISSUE;
                    end else begin
                        holdNext  = imem.imem_rdata;
                        stateNext = HOLD;
                    end
                end else if (branch_taken) begin
                    pcNext    = targetAligned;
                    stateNext = DROP;
                end
            end
            DROP: begin
                // the in-flight word belongs to the old path whatever happens now
                if (branch_taken)     pcNext = targetAligned;
                if (imem.imem_rvalid) stateNext = ISSUE;
            end
            HOLD: begin
                if (branch_taken) begin
                    pcNext    = targetAligned;
                    stateNext = ISSUE;
                end else if (!stall) begin
                    loadEn    = 1'b1;
                    loadInstr = holdInstr;
                    pcNext    = pcPlus4;
                    stateNext = ISSUE;
                end
            end
            default: stateNext = ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ISSUE;
            pc             <= RESET_PC;
            holdInstr      <= '0;
            if_id_valid    <= 1'b0;
            if_id_instr    <= '0;
            if_id_pc_plus4 <= '0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            holdInstr <= holdNext;
            // flush beats stall beats load; otherwise a bubble keeps the old payload
            if (branch_taken) begin
                if_id_valid <= 1'b0;
            end else if (!stall) begin
                if (loadEn) begin
                    if_id_valid    <= 1'b1;
                    if_id_instr    <= loadInstr;
                    if_id_pc_plus4 <= pcPlus4;
                end else begin
                    if_id_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: imem model plus program-order reference feeding a
// scoreboard queue, with an independent monitor checking the IF/ID register.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
    localparam int          PCW      = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [5:0]  if_id_opcode;
    logic [31:0] if_id_pc_plus4;

    instr_fetch_unit_if #(.PC_WIDTH(PCW)) bus ();

    instr_fetch_unit #(.PC_WIDTH(PCW), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (bus),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_opcode   (if_id_opcode),
        .if_id_pc_plus4 (if_id_pc_plus4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // scoreboard: {instr, pc_plus4} of every instruction that must reach IF/ID
    logic [63:0] expQ[$];

    // reference model: architectural next-fetch PC, epoch tags for redirects
    bit          outstanding = 1'b0;
    bit          pendValid = 1'b0;
    bit          justDelivered = 1'b0;
    logic [31:0] memAddr = 32'h0;
    logic [31:0] reqModelAddr = 32'h0;
    logic [31:0] pendWord = 32'h0;
    logic [31:0] pendAddr = 32'h0;
    logic [31:0] expPc = RESET_PC;
    int          epoch = 0;
    int          reqEpoch = 0;
    int          respCycle = 0;
    int          cyc = 0;
    int          latMin = 1;
    int          latMax = 1;

    function automatic logic [31:0] wordOf(input logic [31:0] a);
        return a | 32'h2000_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit br, input logic [31:0] tgt, input bit st, input bit rs);
        bit rv;
        bit expReq;
        @(negedge clk);
        rv = !rs && outstanding && (cyc >= respCycle);
        rst              = rs;
        branch_taken     = br;
        branch_target    = tgt;
        stall            = st;
        bus.imem_rvalid  = rv;
        bus.imem_rdata   = rv ? wordOf(memAddr) : $urandom;
        #1;
        expReq = !rs && !outstanding && !pendValid && !br;
        chk("imem_req", {31'b0, bus.imem_req}, {31'b0, expReq});
        if (expReq && bus.imem_req) chk("imem_addr", bus.imem_addr, expPc);
        justDelivered = 1'b0;
        if (rs) begin
            outstanding = 1'b0;
            pendValid   = 1'b0;
            expPc       = RESET_PC;
            epoch++;
            expQ.delete();
        end else begin
            if (rv) begin
                outstanding = 1'b0;
                if (reqEpoch == epoch && !br) begin
                    pendValid = 1'b1;
                    pendWord  = wordOf(reqModelAddr);
                    pendAddr  = reqModelAddr;
                end
            end
            if (bus.imem_req) begin
                outstanding  = 1'b1;
                memAddr      = bus.imem_addr;
                reqModelAddr = expPc;
                reqEpoch     = epoch;
                respCycle    = cyc + $urandom_range(latMax, latMin);
            end
            if (br) begin
                epoch++;
                expPc     = {tgt[31:2], 2'b00};
                pendValid = 1'b0;
            end else if (pendValid && !st) begin
                expQ.push_back({pendWord, pendAddr + 32'd4});
                expPc         = pendAddr + 32'd4;
                pendValid     = 1'b0;
                justDelivered = 1'b1;
            end
        end
        cyc++;
    endtask

    // monitor: tracks the expected IF/ID contents, pops the scoreboard on each load
    logic [31:0] expInstr = 32'h0;
    logic [31:0] expPc4 = 32'h0;
    bit          expValid = 1'b0;
    initial begin
        logic pRst, pBr, pSt;
        logic [63:0] item;
        forever begin
            @(posedge clk);
            pRst = rst;
            pBr  = branch_taken;
            pSt  = stall;
            #1;
            if (pRst) begin
                expValid = 1'b0;
                expInstr = 32'h0;
                expPc4   = 32'h0;
            end else if (pBr) begin
                expValid = 1'b0;
            end else if (!pSt) begin
                if (if_id_valid === 1'b1) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_load: got instr %h pc_plus4 %h expected no load at %0t", if_id_instr, if_id_pc_plus4, $time);
                    end else begin
                        item     = expQ.pop_front();
                        expValid = 1'b1;
                        expInstr = item[63:32];
                        expPc4   = item[31:0];
                    end
                end else begin
                    expValid = 1'b0;
                end
            end
            chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, expValid});
            chk("if_id_instr", if_id_instr, expInstr);
            chk("if_id_opcode", {26'b0, if_id_opcode}, {26'b0, expInstr[31:26]});
            chk("if_id_pc_plus4", if_id_pc_plus4, expPc4);
        end
    end

    initial begin
        bit reached;
        logic [31:0] tgt;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;

        repeat (3) cycle(0, 32'h0, 0, 1);
        // free run with single-cycle memory
        repeat (12) cycle(0, 32'h0, 0, 0);
        // stall across a returning response
        repeat (3) cycle(0, 32'h0, 1, 0);
        repeat (6) cycle(0, 32'h0, 0, 0);

        // redirect while a slow request is in flight
        latMin = 3; latMax = 3;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            cycle(0, 32'h0, 0, 0);
            reached = outstanding;
        end
        chk("reach_wait", {31'b0, reached}, 32'd1);
        cycle(1, 32'h40, 0, 0);
        latMin = 1; latMax = 1;
        repeat (10) cycle(0, 32'h0, 0, 0);

        // flush beats stall right after a load
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            cycle(0, 32'h0, 0, 0);
            reached = justDelivered;
        end
        chk("reach_load", {31'b0, reached}, 32'd1);
        cycle(1, 32'h40, 1, 0);
        repeat (6) cycle(0, 32'h0, 0, 0);

        // misaligned target and wrap at the top of the address space
        cycle(1, 32'h43, 0, 0);
        repeat (6) cycle(0, 32'h0, 0, 0);
        cycle(1, 32'hFFFF_FFFF, 0, 0);
        repeat (8) cycle(0, 32'h0, 0, 0);

        // reset while a word is parked
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            cycle(0, 32'h0, 1, 0);
            reached = pendValid;
        end
        chk("reach_hold", {31'b0, reached}, 32'd1);
        cycle(0, 32'h0, 1, 1);
        repeat (8) cycle(0, 32'h0, 0, 0);

        // randomized traffic
        latMin = 1; latMax = 4;
        for (int i = 0; i < 1500; i++) begin
            tgt = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
            cycle($urandom_range(0, 99) < 8, tgt, $urandom_range(0, 99) < 30, 0);
        end

        repeat (14) cycle(0, 32'h0, 0, 0);
        @(negedge clk);
        chk("drain", expQ.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
